// File: rtl/loop_count_checker_pkg.sv
// Shared definitions for the loop-counter sequence checker.
// Contents: FSM state encoding and its width, and the widths of the
// wrap and error statistics counters.
package loop_count_checker_pkg;

    localparam int STATE_W    = 2;
    localparam int WRAP_CNT_W = 16;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/loop_count_checker_if.sv
// Loop-counter interface: the counter side (master) drives the sampling
// enable and the count value; the checker side (slave) returns lock status,
// error/wrap pulses and statistics.
//   en, cnt            : master -> slave
//   locked, err, wrap  : slave -> master, status and one-cycle pulses
//   err_sticky         : slave -> master, latched error flag
//   wrap_cnt, err_cnt  : slave -> master, statistics
//   state              : slave -> master, FSM state (IDLE=0, ACQ=1, LOCKED=2)
interface loop_count_checker_if
    import loop_count_checker_pkg::*;
#(
    parameter int WIDTH = 7
);
    logic                  en;
    logic [WIDTH-1:0]      cnt;
    logic                  locked;
    logic                  err;
    logic                  err_sticky;
    logic                  wrap;
    logic [WRAP_CNT_W-1:0] wrap_cnt;
    logic [ERR_CNT_W-1:0]  err_cnt;
    logic [STATE_W-1:0]    state;

    modport master (
        output en, cnt,
        input  locked, err, err_sticky, wrap, wrap_cnt, err_cnt, state
    );

    modport slave (
        input  en, cnt,
        output locked, err, err_sticky, wrap, wrap_cnt, err_cnt, state
    );

endinterface

// File: rtl/loop_count_checker_sat_counter.sv
// Up-counter with increment enable and selectable end behaviour.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count up by one on this edge
//   count    : current value; holds at all-ones when SAT=1, rolls over when SAT=0
module sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !(SAT && (&count))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/loop_count_checker.sv
// Checks that a free-running loop counter steps +1 per enabled sample,
// wrapping from MAX_VAL to 0. Locks after LOCK_LEN correct steps, then
// reports sequence errors and wraps, and keeps error/wrap statistics.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave end of the loop-counter interface (en, cnt in;
//              locked, err, err_sticky, wrap, wrap_cnt, err_cnt, state out)
module loop_count_checker
    import loop_count_checker_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int MAX_VAL  = 99,
    parameter int LOCK_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    loop_count_checker_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [3:0]       LOCK_V = 4'(LOCK_LEN);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       run_q, run_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic             sticky_q;
    logic             locked_q;
    logic             err_inc, wrap_inc;
    logic [WIDTH-1:0] exp_val;
    logic             in_range, step_ok;

    logic [WRAP_CNT_W-1:0] wrap_cnt;
    logic [ERR_CNT_W-1:0]  err_cnt;

    assign exp_val  = (prev_q == MAX_V) ? '0 : prev_q + WIDTH'(1);
    assign in_range = (bus.cnt <= MAX_V);
    assign step_ok  = in_range && (bus.cnt == exp_val);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        err_d    = 1'b0;
        wrap_d   = 1'b0;
        err_inc  = 1'b0;
        wrap_inc = 1'b0;

        if (!bus.en) begin
            // Dropping enable wins over any error in the same sample.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_range) begin
                        prev_d  = bus.cnt;
                        run_d   = '0;
                        state_d = ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    prev_d = bus.cnt;
                    if (step_ok) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == LOCK_V) state_d = ST_LOCKED;
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Always follow the counter so a restarted sequence
                    // yields a single error and then reacquires.
                    prev_d = bus.cnt;
                    if (step_ok) begin
                        wrap_d   = (prev_q == MAX_V);
                        wrap_inc = (prev_q == MAX_V);
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        run_d   = '0;
                        state_d = ST_ACQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            run_q    <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_q | err_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    sat_counter #(.W(ERR_CNT_W), .SAT(1'b1)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (err_cnt)
    );

    sat_counter #(.W(WRAP_CNT_W), .SAT(1'b0)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wrap_inc),
        .count (wrap_cnt)
    );

    assign bus.state      = state_q;
    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.wrap       = wrap_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = err_cnt;
    assign bus.wrap_cnt   = wrap_cnt;

endmodule

// File: tb/tb_loop_count_checker.sv
// Bench for loop_count_checker: directed count sequences with hand-computed
// expected outputs, queued at each sampling edge and compared by a separate
// monitor on the following falling edge.
module tb_loop_count_checker;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    typedef struct {
        logic [1:0]  st;
        logic        err;
        logic        wrap;
        logic        sticky;
        logic [7:0]  ec;
        logic [15:0] wc;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t q[$];

    logic        e_sticky;
    logic [7:0]  e_err_cnt;
    logic [15:0] e_wrap_cnt;

    loop_count_checker_if #(.WIDTH(7)) bus ();

    loop_count_checker #(.WIDTH(7), .MAX_VAL(99), .LOCK_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one sample, then queue what the outputs must show after that edge.
    task automatic step(input logic e, input logic [6:0] c, input logic [1:0] st,
                        input logic er, input logic wr);
        exp_t x;
        bus.en  = e;
        bus.cnt = c;
        @(posedge clk);
        x.st = st; x.err = er; x.wrap = wr;
        x.sticky = e_sticky; x.ec = e_err_cnt; x.wc = e_wrap_cnt;
        q.push_back(x);
        #1;
    endtask

    task automatic count_err();
        e_sticky = 1'b1;
        if (e_err_cnt != 8'd255) e_err_cnt = e_err_cnt + 8'd1;
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                check("state",      32'(bus.state),      32'(x.st));
                check("locked",     32'(bus.locked),     32'(x.st == LOCKED));
                check("err",        32'(bus.err),        32'(x.err));
                check("wrap",       32'(bus.wrap),       32'(x.wrap));
                check("err_sticky", 32'(bus.err_sticky), 32'(x.sticky));
                check("err_cnt",    32'(bus.err_cnt),    32'(x.ec));
                check("wrap_cnt",   32'(bus.wrap_cnt),   32'(x.wc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        e_sticky = 1'b0; e_err_cnt = 8'd0; e_wrap_cnt = 16'd0;
        rst = 1'b1; bus.en = 1'b0; bus.cnt = '0;
        #3;
        check("rst_state",  32'(bus.state),      32'd0);
        check("rst_locked", 32'(bus.locked),     32'd0);
        check("rst_err",    32'(bus.err),        32'd0);
        check("rst_errcnt", 32'(bus.err_cnt),    32'd0);
        check("rst_wrpcnt", 32'(bus.wrap_cnt),   32'd0);
        #9 rst = 1'b0;

        // Lock: 10..14, locked at the fifth sample.
        step(1, 10, ACQ, 0, 0);
        step(1, 11, ACQ, 0, 0);
        step(1, 12, ACQ, 0, 0);
        step(1, 13, ACQ, 0, 0);
        step(1, 14, LOCKED, 0, 0);

        // Wrap: relock at 98, then 99 -> 0 -> 1.
        step(0, 0, IDLE, 0, 0);
        step(1, 94, ACQ, 0, 0);
        step(1, 95, ACQ, 0, 0);
        step(1, 96, ACQ, 0, 0);
        step(1, 97, ACQ, 0, 0);
        step(1, 98, LOCKED, 0, 0);
        step(1, 99, LOCKED, 0, 0);
        e_wrap_cnt = 16'd1;
        step(1, 0, LOCKED, 0, 1);
        step(1, 1, LOCKED, 0, 0);

        // Error: locked at 20, skip to 22, then relock over 23..26.
        step(0, 0, IDLE, 0, 0);
        step(1, 16, ACQ, 0, 0);
        step(1, 17, ACQ, 0, 0);
        step(1, 18, ACQ, 0, 0);
        step(1, 19, ACQ, 0, 0);
        step(1, 20, LOCKED, 0, 0);
        count_err();
        step(1, 22, ACQ, 1, 0);
        step(1, 23, ACQ, 0, 0);
        step(1, 24, ACQ, 0, 0);
        step(1, 25, ACQ, 0, 0);
        step(1, 26, LOCKED, 0, 0);

        // Counter reset: hold 0 five times, one err only, relock at 4.
        count_err();
        step(1, 0, ACQ, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, ACQ, 0, 0);
        step(1, 1, ACQ, 0, 0);
        step(1, 2, ACQ, 0, 0);
        step(1, 3, ACQ, 0, 0);
        step(1, 4, LOCKED, 0, 0);

        // Out of range: locked at 99, then 100; 120 in IDLE stays IDLE.
        step(0, 0, IDLE, 0, 0);
        step(1, 95, ACQ, 0, 0);
        step(1, 96, ACQ, 0, 0);
        step(1, 97, ACQ, 0, 0);
        step(1, 98, ACQ, 0, 0);
        step(1, 99, LOCKED, 0, 0);
        count_err();
        step(1, 100, ACQ, 1, 0);
        step(0, 0, IDLE, 0, 0);
        step(1, 120, IDLE, 0, 0);
        step(1, 120, IDLE, 0, 0);

        // Saturation: 297 more errors bring the total to 300.
        step(1, 0, ACQ, 0, 0);
        for (int i = 0; i < 297; i++) begin
            step(1, 1, ACQ, 0, 0);
            step(1, 2, ACQ, 0, 0);
            step(1, 3, ACQ, 0, 0);
            step(1, 4, LOCKED, 0, 0);
            count_err();
            step(1, 0, ACQ, 1, 0);
        end

        // Enable drop: IDLE, statistics held.
        step(0, 0, IDLE, 0, 0);
        step(0, 55, IDLE, 0, 0);

        // Let the monitor drain, then assert reset between edges.
        #6;
        check("queue_empty", 32'(q.size()), 32'd0);
        check("pre_rst_errcnt", 32'(bus.err_cnt), 32'd255);
        rst = 1'b1;
        #1;
        check("arst_state",  32'(bus.state),      32'd0);
        check("arst_locked", 32'(bus.locked),     32'd0);
        check("arst_err",    32'(bus.err),        32'd0);
        check("arst_sticky", 32'(bus.err_sticky), 32'd0);
        check("arst_wrap",   32'(bus.wrap),       32'd0);
        check("arst_errcnt", 32'(bus.err_cnt),    32'd0);
        check("arst_wrpcnt", 32'(bus.wrap_cnt),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
